// File: rtl/div_arbiter.sv
// Two-requester front end for a single shared signed divider.
// Requests are granted round-robin on ties. A zero divisor is answered
// locally without touching the divider. A divider that stays busy for
// TIMEOUT cycles is abandoned and the response carries res_to instead.
module div_arbiter #(
    parameter int TIMEOUT = 64,
    parameter int DATA_W  = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     req0,
    input  logic                     req1,
    input  logic signed [DATA_W-1:0] dividend0,
    input  logic signed [DATA_W-1:0] divisor0,
    input  logic signed [DATA_W-1:0] dividend1,
    input  logic signed [DATA_W-1:0] divisor1,
    output logic                     div_start,
    output logic signed [DATA_W-1:0] div_dividend,
    output logic signed [DATA_W-1:0] div_divisor,
    input  logic                     div_busy,
    input  logic signed [DATA_W-1:0] div_q,
    input  logic signed [DATA_W-1:0] div_r,
    output logic                     done,
    output logic                     done_id,
    output logic signed [DATA_W-1:0] res_q,
    output logic signed [DATA_W-1:0] res_r,
    output logic                     res_dz,
    output logic                     res_to,
    output logic                     busy
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic                      r_grant;
    logic                      r_last_grant;
    logic [CNT_W-1:0]          r_cnt;

    logic                      w_grant;
    logic                      w_load;
    logic                      w_dz;
    logic                      w_cap;
    logic                      w_tout;
    logic                      w_clr_cnt;
    logic                      w_inc_cnt;
    logic signed [DATA_W-1:0]  w_sel_dividend;
    logic signed [DATA_W-1:0]  w_sel_divisor;

    // Round-robin pick: a lone requester wins outright; on a tie the
    // requester that did not win last time is served.
    function automatic logic pick_grant(input logic r0, input logic r1,
                                        input logic last);
        if (r0 && r1)
            return ~last;
        return r0 ? 1'b0 : 1'b1;
    endfunction

    // Operand mux driven by the requester being granted this cycle.
    always_comb begin
        w_grant        = pick_grant(req0, req1, r_last_grant);
        w_sel_dividend = w_grant ? dividend1 : dividend0;
        w_sel_divisor  = w_grant ? divisor1  : divisor0;
    end

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next-state decode, datapath strobes and state-derived outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_dz        = 1'b0;
        w_cap       = 1'b0;
        w_tout      = 1'b0;
        w_clr_cnt   = 1'b0;
        w_inc_cnt   = 1'b0;
        div_start   = 1'b0;
        done        = 1'b0;
        busy        = 1'b1;
        done_id     = r_grant;
        unique case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (req0 || req1) begin
                    w_load = 1'b1;
                    if (w_sel_divisor == '0) begin
                        w_dz        = 1'b1;
                        w_state_nxt = RESP;
                    end else begin
                        w_state_nxt = ISSUE;
                    end
                end
            end
            ISSUE: begin
                div_start   = 1'b1;
                w_clr_cnt   = 1'b1;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (!div_busy) begin
                    w_cap       = 1'b1;
                    w_state_nxt = RESP;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    // This is the TIMEOUT-th busy cycle: give up.
                    w_tout      = 1'b1;
                    w_state_nxt = RESP;
                end else begin
                    w_inc_cnt = 1'b1;
                end
            end
            RESP: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Grant bookkeeping and the busy-cycle counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_cnt        <= '0;
        end else begin
            if (w_load) begin
                r_grant      <= w_grant;
                r_last_grant <= w_grant;
            end
            if (w_clr_cnt)
                r_cnt <= '0;
            else if (w_inc_cnt)
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Operands go to the divider only for a non-zero divisor.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_dividend <= '0;
            div_divisor  <= '0;
        end else if (w_load && !w_dz) begin
            div_dividend <= w_sel_dividend;
            div_divisor  <= w_sel_divisor;
        end
    end

    // Result registers change only on the way into RESP and hold otherwise.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            res_q  <= '0;
            res_r  <= '0;
            res_dz <= 1'b0;
            res_to <= 1'b0;
        end else if (w_load && w_dz) begin
            res_q  <= '1;
            res_r  <= w_sel_dividend;
            res_dz <= 1'b1;
            res_to <= 1'b0;
        end else if (w_cap) begin
            res_q  <= div_q;
            res_r  <= div_r;
            res_dz <= 1'b0;
            res_to <= 1'b0;
        end else if (w_tout) begin
            res_q  <= '0;
            res_r  <= '0;
            res_dz <= 1'b0;
            res_to <= 1'b1;
        end
    end

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter with a behavioural single-cycle divider
// whose busy flag can be held high by the stimulus.
`timescale 1ns/1ps
module tb_div_arbiter;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic               reset;
    logic               req0, req1;
    logic signed [31:0] dividend0, divisor0, dividend1, divisor1;
    logic               div_start;
    logic signed [31:0] div_dividend, div_divisor;
    logic               div_busy;
    logic signed [31:0] div_q, div_r;
    logic               done, done_id;
    logic signed [31:0] res_q, res_r;
    logic               res_dz, res_to, busy;

    int n_cmp   = 0;
    int n_err   = 0;
    int n_start = 0;
    int n_done  = 0;
    int lat;
    int saved;

    // Divider answers from whatever operands the arbiter presents.
    assign div_q = (div_divisor != 0) ? (div_dividend / div_divisor) : 32'sd0;
    assign div_r = (div_divisor != 0) ? (div_dividend % div_divisor) : 32'sd0;

    div_arbiter #(.TIMEOUT(64)) dut (
        .clock        (clock),
        .reset        (reset),
        .req0         (req0),
        .req1         (req1),
        .dividend0    (dividend0),
        .divisor0     (divisor0),
        .dividend1    (dividend1),
        .divisor1     (divisor1),
        .div_start    (div_start),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_busy     (div_busy),
        .div_q        (div_q),
        .div_r        (div_r),
        .done         (done),
        .done_id      (done_id),
        .res_q        (res_q),
        .res_r        (res_r),
        .res_dz       (res_dz),
        .res_to       (res_to),
        .busy         (busy)
    );

    // Pulse counters sampled on the clock edge.
    always @(posedge clock) begin
        if (div_start) n_start <= n_start + 1;
        if (done)      n_done  <= n_done + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] act,
                            input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Steps until done is seen; returns the number of steps or -1.
    task automatic wait_done(input int limit, output int cyc);
        cyc = -1;
        for (int i = 1; i <= limit; i++) begin
            step();
            if (done) begin
                cyc = i;
                return;
            end
        end
    endtask

    initial begin
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0; div_busy = 1'b0;
        dividend0 = 0; divisor0 = 0; dividend1 = 0; divisor1 = 0;
        step(); step();
        check_eq("rst_busy",   32'(busy), 32'd0);
        check_eq("rst_done",   32'(done), 32'd0);
        check_eq("rst_id",     32'(done_id), 32'd0);
        check_eq("rst_start",  32'(div_start), 32'd0);
        check_eq("rst_dvd",    div_dividend, 32'd0);
        check_eq("rst_dvs",    div_divisor, 32'd0);
        check_eq("rst_q",      res_q, 32'd0);
        check_eq("rst_r",      res_r, 32'd0);
        check_eq("rst_flags",  {30'd0, res_dz, res_to}, 32'd0);
        reset = 1'b0;
        step();

        // 100 / 7 from requester 0, immediate divider.
        dividend0 = 100; divisor0 = 7; req0 = 1'b1;
        step();
        check_eq("c1_start",   32'(div_start), 32'd1);
        check_eq("c1_dvd",     div_dividend, 32'd100);
        check_eq("c1_dvs",     div_divisor, 32'd7);
        check_eq("c1_done",    32'(done), 32'd0);
        step();
        check_eq("c2_start",   32'(div_start), 32'd0);
        check_eq("c2_done",    32'(done), 32'd0);
        step();
        check_eq("c3_done",    32'(done), 32'd1);
        check_eq("c3_id",      32'(done_id), 32'd0);
        check_eq("c3_q",       res_q, 32'd14);
        check_eq("c3_r",       res_r, 32'd2);
        check_eq("c3_flags",   {30'd0, res_dz, res_to}, 32'd0);
        req0 = 1'b0;
        step();
        check_eq("c4_done",    32'(done), 32'd0);
        check_eq("c4_busy",    32'(busy), 32'd0);
        step();
        check_eq("hold_q",     res_q, 32'd14);

        // Tie straight out of reset: requester 0 first, then 1.
        reset = 1'b1; step(); reset = 1'b0;
        dividend0 = 50; divisor0 = 6; dividend1 = -7; divisor1 = 2;
        req0 = 1'b1; req1 = 1'b1;
        wait_done(10, lat);
        check_eq("tie1_lat",   lat, 32'd3);
        check_eq("tie1_id",    32'(done_id), 32'd0);
        check_eq("tie1_q",     res_q, 32'd8);
        check_eq("tie1_r",     res_r, 32'd2);
        req0 = 1'b0;
        wait_done(10, lat);
        check_eq("tie1b_lat",  lat, 32'd4);
        check_eq("tie1b_id",   32'(done_id), 32'd1);
        check_eq("tie1b_q",    res_q, 32'hFFFF_FFFD);
        check_eq("tie1b_r",    res_r, 32'hFFFF_FFFF);
        req1 = 1'b0;
        step();
        req0 = 1'b1; req1 = 1'b1;
        wait_done(10, lat);
        check_eq("tie2_id",    32'(done_id), 32'd0);
        req0 = 1'b0;
        wait_done(10, lat);
        check_eq("tie2b_id",   32'(done_id), 32'd1);
        req1 = 1'b0;
        step();

        // -100 / 0 from requester 1: answered without the divider.
        saved = n_start;
        dividend1 = -100; divisor1 = 0; req1 = 1'b1;
        step();
        check_eq("dz1_done",   32'(done), 32'd1);
        check_eq("dz1_id",     32'(done_id), 32'd1);
        check_eq("dz1_dz",     32'(res_dz), 32'd1);
        check_eq("dz1_to",     32'(res_to), 32'd0);
        check_eq("dz1_q",      res_q, 32'hFFFF_FFFF);
        check_eq("dz1_r",      res_r, 32'hFFFF_FF9C);
        check_eq("dz1_dvs",    div_divisor, 32'd2);
        req1 = 1'b0;
        step();
        check_eq("dz1_nostart", n_start, saved);

        // Zero divisor from requester 0 still moves the round-robin pointer.
        dividend0 = 5; divisor0 = 0; req0 = 1'b1;
        step();
        check_eq("dz0_done",   32'(done), 32'd1);
        check_eq("dz0_id",     32'(done_id), 32'd0);
        check_eq("dz0_r",      res_r, 32'd5);
        req0 = 1'b0;
        step();
        dividend0 = 50; divisor0 = 6; dividend1 = -7; divisor1 = 2;
        req0 = 1'b1; req1 = 1'b1;
        wait_done(10, lat);
        check_eq("tie3_id",    32'(done_id), 32'd1);
        check_eq("tie3_dz",    32'(res_dz), 32'd0);
        req1 = 1'b0;
        wait_done(10, lat);
        check_eq("tie3b_id",   32'(done_id), 32'd0);
        req0 = 1'b0;
        step();

        // Divider stuck busy: abort after 64 busy WAIT cycles.
        div_busy = 1'b1;
        dividend0 = 100; divisor0 = 7; req0 = 1'b1;
        step();
        check_eq("to_start",   32'(div_start), 32'd1);
        step();
        check_eq("to_busy",    32'(busy), 32'd1);
        wait_done(200, lat);
        check_eq("to_lat",     lat, 32'd64);
        check_eq("to_id",      32'(done_id), 32'd0);
        check_eq("to_to",      32'(res_to), 32'd1);
        check_eq("to_dz",      32'(res_dz), 32'd0);
        check_eq("to_q",       res_q, 32'd0);
        check_eq("to_r",       res_r, 32'd0);
        req0 = 1'b0;
        div_busy = 1'b0;
        step();

        // Reset in the middle of WAIT.
        div_busy = 1'b1;
        dividend1 = 9; divisor1 = 4; req1 = 1'b1;
        step(); step(); step();
        check_eq("rw_busy_pre", 32'(busy), 32'd1);
        saved = n_done;
        reset = 1'b1;
        #1;
        check_eq("rw_busy",    32'(busy), 32'd0);
        check_eq("rw_done",    32'(done), 32'd0);
        check_eq("rw_start",   32'(div_start), 32'd0);
        step();
        reset = 1'b0;
        div_busy = 1'b0;
        check_eq("rw_nodone",  n_done, saved);
        wait_done(20, lat);
        check_eq("rw_lat",     lat, 32'd3);
        check_eq("rw_id",      32'(done_id), 32'd1);
        check_eq("rw_q",       res_q, 32'd2);
        check_eq("rw_r",       res_r, 32'd1);
        req1 = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
